xor_fold_sequencer: RTL and testbench

- Time-multiplexed XOR reduction controller. Replaces an (N-1)-instance xor2 tree with a single shared xor2 unit plus an accumulator.
- Accepts a frame of up to N operands of WIDTH bits, one per handshake, over a valid/ready stream. Emits the folded XOR result and the operand count on an output valid/ready stream.
- Sits between an operand producer and a result consumer in area-constrained fold/reduce datapaths.

---
 rtl/xor_fold_pkg.sv | 16 +
 rtl/xor_acc_datapath.sv | 35 +++
 rtl/xor_fold_sequencer.sv | 111 +++++++++++
 tb/tb_xor_fold_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_fold_pkg.sv
// Shared definitions for the XOR fold sequencer: state encoding and the
// count-width helper used to size O_count.
package xor_fold_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t ACCUM = 2'd1;
   localparam state_t DONE  = 2'd2;

   // Bits needed to hold an operand count in the range 0..n.
   function automatic int calc_cw(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/xor_acc_datapath.sv
// Accumulator datapath: one shared xor2 unit feeding the acc register.
// The controller asserts at most one of load/fold per cycle, and only on an
// accepted operand, so the operand bus is never captured while it is
// don't-care.
module xor_acc_datapath #(
   parameter int WIDTH = 2
) (
   input  logic             CLK,
   input  logic             ASYNCRESETN,
   input  logic             load,
   input  logic             fold,
   input  logic             clear,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] acc
);

   logic [WIDTH-1:0] xor_out;

   // The single xor2 instance shared by every fold step of a frame.
   assign xor_out = acc ^ operand;

   // acc register: clear wins, then load of the first operand, then fold.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (load) begin
         acc <= operand;
      end else if (fold) begin
         acc <= xor_out;
      end
   end

endmodule

// File: rtl/xor_fold_sequencer.sv
// Time-multiplexed XOR reduction controller. Folds up to N operands per frame
// through one shared xor2 unit and emits the result plus operand count.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for the first operand of a frame; acc and cnt are 0
// ACCUM | frame open, folding further operands into acc
// DONE  | result presented on O_*, input stalled until handshake
module xor_fold_sequencer
   import xor_fold_pkg::*;
#(
   parameter  int WIDTH = 2,
   parameter  int N     = 4,
   localparam int CW    = calc_cw(N)
) (
   input  logic             CLK,
   input  logic             ASYNCRESETN,
   input  logic             I_valid,
   output logic             I_ready,
   input  logic [WIDTH-1:0] I_data,
   input  logic             I_last,
   output logic             O_valid,
   input  logic             O_ready,
   output logic [WIDTH-1:0] O_data,
   output logic [CW-1:0]    O_count,
   output logic             busy
);

   localparam logic [CW-1:0] N_CW = CW'(N);

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_inc;
   logic [WIDTH-1:0] acc;
   logic             in_acc;
   logic             out_hs;
   logic             close;
   logic             load;
   logic             fold;

   assign I_ready = (state == IDLE) || (state == ACCUM);
   assign O_valid = (state == DONE);
   assign busy    = (state == ACCUM) || (state == DONE);

   assign in_acc  = I_valid & I_ready;
   assign out_hs  = O_valid & O_ready;

   // cnt is 0 in IDLE, so cnt_inc is the operand number in both open states;
   // N==1 therefore closes on the first accept without a special case.
   assign cnt_inc = cnt + CW'(1);
   assign close   = I_last | (cnt_inc == N_CW);

   assign load    = in_acc & (state == IDLE);
   assign fold    = in_acc & (state == ACCUM);

   // Result bus is masked to zero whenever no result is being offered.
   assign O_data  = O_valid ? acc : '0;
   assign O_count = O_valid ? cnt : '0;

   xor_acc_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .CLK         (CLK),
      .ASYNCRESETN (ASYNCRESETN),
      .load        (load),
      .fold        (fold),
      .clear       (out_hs),
      .operand     (I_data),
      .acc         (acc)
   );

   // Next-state decode; I_last only matters on an accepted operand.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, ACCUM: begin
            if (in_acc) begin
               state_nxt = close ? DONE : ACCUM;
            end
         end
         DONE: begin
            if (out_hs) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operand counter: cleared when the result is taken, bumped per accept.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         cnt <= '0;
      end else if (out_hs) begin
         cnt <= '0;
      end else if (in_acc) begin
         cnt <= cnt_inc;
      end
   end

endmodule

// File: tb/tb_xor_fold_sequencer.sv
// Bench for xor_fold_sequencer: cycle table for the basic frames, an
// independent frame model feeding a result scoreboard, and hand-written
// sequences for backpressure, back-to-back frames, reset and the N=1 build.
module tb_xor_fold_sequencer;

   logic       CLK = 1'b0;
   logic       ASYNCRESETN = 1'b0;
   logic       I_valid = 1'b0;
   logic       I_last = 1'b0;
   logic [1:0] I_data = 2'b00;
   logic       O_ready = 1'b1;
   logic       I_ready;
   logic       O_valid;
   logic [1:0] O_data;
   logic [2:0] O_count;
   logic       busy;

   logic       v1 = 1'b0;
   logic       l1 = 1'b0;
   logic [1:0] d1 = 2'b00;
   logic       r1 = 1'b0;
   logic       ir1;
   logic       ov1;
   logic [1:0] od1;
   logic [0:0] oc1;
   logic       busy1;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 CLK = ~CLK;

   xor_fold_sequencer #(.WIDTH(2), .N(4)) u_dut (
      .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
      .I_valid(I_valid), .I_ready(I_ready), .I_data(I_data), .I_last(I_last),
      .O_valid(O_valid), .O_ready(O_ready), .O_data(O_data), .O_count(O_count),
      .busy(busy)
   );

   xor_fold_sequencer #(.WIDTH(2), .N(1)) u_dut_n1 (
      .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
      .I_valid(v1), .I_ready(ir1), .I_data(d1), .I_last(l1),
      .O_valid(ov1), .O_ready(r1), .O_data(od1), .O_count(oc1),
      .busy(busy1)
   );

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Frame model and scoreboard. Evaluated on the falling edge, where inputs
   // are stable for the coming rising edge.
   typedef struct packed {
      logic [1:0] d;
      logic [2:0] c;
   } res_t;

   res_t       sb_q[$];
   int         m_state = 0;
   logic [1:0] m_acc = 2'b00;
   int         m_cnt = 0;

   always @(negedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         m_state = 0;
         m_acc   = 2'b00;
         m_cnt   = 0;
         sb_q.delete();
      end else begin
         res_t r;
         check("model_o_valid", O_valid, (m_state == 2) ? 1 : 0);
         if (O_valid && O_ready) begin
            if (sb_q.size() == 0) begin
               total_cnt++;
               $display("FAIL sb_unexpected: result data %0d count %0d with no expected entry", O_data, O_count);
            end else begin
               r = sb_q.pop_front();
               check("sb_data", O_data, r.d);
               check("sb_count", O_count, r.c);
            end
         end
         if (m_state == 2) begin
            if (O_ready) m_state = 0;
         end else if (I_valid) begin
            m_acc = (m_state == 0) ? I_data : (m_acc ^ I_data);
            m_cnt = (m_state == 0) ? 1 : m_cnt + 1;
            if (I_last || m_cnt == 4) begin
               sb_q.push_back({m_acc, 3'(m_cnt)});
               m_state = 2;
            end else begin
               m_state = 1;
            end
         end
      end
   end

   typedef struct {
      logic       v;
      logic [1:0] d;
      logic       l;
      logic       r;
      logic       e_ir;
      logic       e_ov;
      logic [1:0] e_od;
      logic [2:0] e_oc;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic [1:0] bp_ops[4];
      logic [1:0] bb_ops[8];
      int bp_pat[7];
      int k, bubbles, results;
      bit seen;

      // {valid, data, last, o_ready} driven this cycle | outputs expected this cycle
      tbl[0]  = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'd0};
      tbl[1]  = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'd0};
      tbl[2]  = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'd0};
      tbl[3]  = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'd0};
      tbl[4]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'd4};
      tbl[5]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'd4};
      tbl[6]  = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'd0};
      tbl[7]  = '{1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 3'd0};
      tbl[8]  = '{1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 3'd2};
      tbl[9]  = '{1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 3'd0};
      tbl[10] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 3'd1};
      tbl[11] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'd0};

      bp_ops = '{2'b01, 2'b10, 2'b10, 2'b11};
      bp_pat = '{1, 0, 0, 1, 1, 0, 1};
      bb_ops = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b01, 2'b00};

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      check("rst_o_valid", O_valid, 0);
      check("rst_o_count", O_count, 0);
      ASYNCRESETN = 1'b1;
      @(negedge CLK);
      check("rst_i_ready", I_ready, 1);
      check("rst_o_data", O_data, 0);
      check("rst_busy", busy, 0);

      // Full frame and early termination, cycle by cycle
      for (int i = 0; i < 12; i++) begin
         @(posedge CLK);
         #1;
         I_valid = tbl[i].v;
         I_data  = tbl[i].d;
         I_last  = tbl[i].l;
         O_ready = tbl[i].r;
         @(negedge CLK);
         check($sformatf("vec%0d_i_ready", i), I_ready, tbl[i].e_ir);
         check($sformatf("vec%0d_o_valid", i), O_valid, tbl[i].e_ov);
         check($sformatf("vec%0d_o_data", i), O_data, tbl[i].e_od);
         check($sformatf("vec%0d_o_count", i), O_count, tbl[i].e_oc);
      end

      // Backpressure and input gaps; don't-care inputs randomised when idle
      k = 0;
      O_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(posedge CLK);
         #1;
         I_valid = bp_pat[i][0];
         if (bp_pat[i] != 0) begin
            I_data = bp_ops[k];
            I_last = 1'b0;
            k++;
         end else begin
            I_data = 2'($urandom);
            I_last = 1'($urandom);
         end
      end
      @(posedge CLK);
      #1;
      I_valid = 1'b0;
      I_last  = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         check("bp_hold_o_valid", O_valid, 1);
         check("bp_hold_o_data", O_data, 2'b10);
         check("bp_hold_o_count", O_count, 4);
         check("bp_hold_i_ready", I_ready, 0);
         @(posedge CLK);
         #1;
      end
      O_ready = 1'b1;
      @(negedge CLK);
      check("bp_release_o_valid", O_valid, 1);
      @(negedge CLK);
      check("bp_after_i_ready", I_ready, 1);
      check("bp_after_o_valid", O_valid, 0);
      check("bp_after_busy", busy, 0);

      // Back-to-back frames with I_valid held high: one bubble between them
      k = 0;
      bubbles = 0;
      results = 0;
      @(posedge CLK);
      #1;
      I_valid = 1'b1;
      I_data  = bb_ops[0];
      I_last  = 1'b0;
      for (int cyc = 0; cyc < 30 && results < 2; cyc++) begin
         @(negedge CLK);
         if (O_valid && O_ready) results++;
         if (k < 8) begin
            if (I_ready) k++;
            else bubbles++;
         end
         @(posedge CLK);
         #1;
         if (k < 8) I_data = bb_ops[k];
         else I_valid = 1'b0;
      end
      check("b2b_results", results, 2);
      check("b2b_bubbles", bubbles, 1);

      // Reset mid-frame, pulsed between clock edges
      @(posedge CLK);
      #1;
      I_valid = 1'b1;
      I_data  = 2'b01;
      @(posedge CLK);
      #1;
      I_data  = 2'b10;
      @(posedge CLK);
      #1;
      I_valid = 1'b0;
      check("mid_busy_before_rst", busy, 1);
      #1;
      ASYNCRESETN = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_o_valid", O_valid, 0);
      check("mid_rst_o_count", O_count, 0);
      check("mid_rst_i_ready", I_ready, 1);
      #1;
      ASYNCRESETN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK);
         #1;
         I_valid = 1'b1;
         I_data  = 2'b11;
         I_last  = 1'b0;
      end
      @(posedge CLK);
      #1;
      I_valid = 1'b0;
      seen = 1'b0;
      for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
         @(negedge CLK);
         if (O_valid) begin
            seen = 1'b1;
            check("post_rst_o_data", O_data, 0);
            check("post_rst_o_count", O_count, 4);
         end
      end
      check("post_rst_result_seen", seen, 1);
      @(posedge CLK);
      #1;

      // N=1 build: every accept closes the frame with count 1
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK);
         #1;
         v1 = 1'b1;
         d1 = 2'(i);
         l1 = 1'(i);
         r1 = 1'b0;
         @(negedge CLK);
         check($sformatf("n1_%0d_idle_i_ready", i), ir1, 1);
         check($sformatf("n1_%0d_idle_o_valid", i), ov1, 0);
         @(posedge CLK);
         #1;
         d1 = ~2'(i);
         @(negedge CLK);
         check($sformatf("n1_%0d_o_valid", i), ov1, 1);
         check($sformatf("n1_%0d_o_data", i), od1, i);
         check($sformatf("n1_%0d_o_count", i), oc1, 1);
         check($sformatf("n1_%0d_i_ready", i), ir1, 0);
         r1 = 1'b1;
         @(posedge CLK);
         #1;
         v1 = 1'b0;
         r1 = 1'b0;
         @(negedge CLK);
         check($sformatf("n1_%0d_single_result", i), ov1, 0);
         check($sformatf("n1_%0d_back_idle", i), ir1, 1);
      end

      check("sb_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
